// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data aligner: the pipeline (A) normally wins,
// the loader/debug port (B) gets a forced grant after STARVE_LIMIT lost contended cycles.
`ifndef DM_NONE
`define DM_NONE 2'b00
`define DM_BYTE 2'b01
`define DM_HALF 2'b10
`define DM_WORD 2'b11
`endif

module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [1:0]  a_read_status,
  input  logic [1:0]  a_write_status,
  input  logic        a_load_signed,
  output logic        a_grant,
  output logic        a_stall,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [1:0]  b_read_status,
  input  logic [1:0]  b_write_status,
  output logic        b_grant,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_read_status,
  output logic [1:0]  m_write_status,
  output logic        m_load_signed,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       owner_a_q, owner_a_d;
  logic       owner_b_q, owner_b_d;
  logic       gnt_a, gnt_b;

  // B wins when A is absent or B has lost LIMIT contended cycles in a row.
  always_comb begin
    gnt_b = rst_n & b_req & (~a_req | (starve_cnt_q == LIMIT));
    gnt_a = rst_n & a_req & ~gnt_b;
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (a_req && b_req && gnt_a)
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    owner_a_d = gnt_a & (a_read_status != `DM_NONE);
    owner_b_d = gnt_b & (b_read_status != `DM_NONE);
  end

  always_comb begin
    m_addr         = 32'd0;
    m_wdata        = 32'd0;
    m_read_status  = `DM_NONE;
    m_write_status = `DM_NONE;
    m_load_signed  = 1'b0;
    if (gnt_a) begin
      m_addr         = a_addr;
      m_wdata        = a_wdata;
      m_read_status  = a_read_status;
      m_write_status = a_write_status;
      m_load_signed  = a_load_signed;
    end else if (gnt_b) begin
      m_addr         = b_addr;
      m_wdata        = b_wdata;
      m_read_status  = b_read_status;
      m_write_status = b_write_status;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      owner_a_q    <= 1'b0;
      owner_b_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_a_q    <= owner_a_d;
      owner_b_q    <= owner_b_d;
    end
  end

  // Gating with rst_n drops a response whose reset lands in its return cycle.
  always_comb begin
    a_grant  = gnt_a;
    b_grant  = gnt_b;
    a_stall  = rst_n & a_req & ~gnt_a;
    a_rvalid = rst_n & owner_a_q;
    b_rvalid = rst_n & owner_b_q;
    a_rdata  = a_rvalid ? m_rdata : 32'd0;
    b_rdata  = b_rvalid ? m_rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single-port accesses, back-to-back
// reads, starvation rotation and mid-operation reset.
module tb_dmem_arbiter;
  localparam logic [1:0] DM_NONE = 2'b00;
  localparam logic [1:0] DM_BYTE = 2'b01;
  localparam logic [1:0] DM_WORD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_load_signed, a_grant, a_stall, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_read_status, a_write_status;
  logic        b_req, b_grant, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_read_status, b_write_status;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_read_status, m_write_status;
  logic        m_load_signed;

  int n_chk = 0;
  int n_pass = 0;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_read_status(a_read_status), .a_write_status(a_write_status),
    .a_load_signed(a_load_signed), .a_grant(a_grant), .a_stall(a_stall),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_read_status(b_read_status), .b_write_status(b_write_status),
    .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read_status(m_read_status),
    .m_write_status(m_write_status), .m_load_signed(m_load_signed),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic idle();
    a_req = 0; a_addr = 0; a_wdata = 0; a_read_status = DM_NONE;
    a_write_status = DM_NONE; a_load_signed = 0;
    b_req = 0; b_addr = 0; b_wdata = 0; b_read_status = DM_NONE;
    b_write_status = DM_NONE; m_rdata = 0;
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_agnt"}, a_grant, 0);
    chk({tag, "_bgnt"}, b_grant, 0);
    chk({tag, "_stall"}, a_stall, 0);
    chk({tag, "_mrs"}, m_read_status, DM_NONE);
    chk({tag, "_mws"}, m_write_status, DM_NONE);
    chk({tag, "_maddr"}, m_addr, 0);
  endtask

  task automatic both_rot(input string tag, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      a_req = 1; b_req = 1; a_addr = 32'hA0; b_addr = 32'hB0; a_load_signed = 1;
      #1;
      chk($sformatf("%s_agnt%0d", tag, i), a_grant, !pat[i]);
      chk($sformatf("%s_bgnt%0d", tag, i), b_grant, pat[i]);
      chk($sformatf("%s_stall%0d", tag, i), a_stall, pat[i]);
      chk($sformatf("%s_maddr%0d", tag, i), m_addr, pat[i] ? 32'hB0 : 32'hA0);
      chk($sformatf("%s_msgn%0d", tag, i), m_load_signed, !pat[i]);
      tick();
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    // Reset with both ports requesting: nothing issued.
    a_req = 1; b_req = 1; a_read_status = DM_WORD; b_read_status = DM_WORD;
    #1; chk_quiet("rst");
    tick(); tick();
    chk("rst_arv", a_rvalid, 0); chk("rst_brv", b_rvalid, 0);
    chk("rst_ard", a_rdata, 0);  chk("rst_brd", b_rdata, 0);

    // Release and go idle.
    idle(); rst_n = 1; #1;
    chk_quiet("idle");
    chk("idle_arv", a_rvalid, 0);
    tick();

    // A-only word load.
    a_req = 1; a_addr = 32'h0010_0004; a_read_status = DM_WORD; a_load_signed = 1;
    #1;
    chk("ald_gnt", a_grant, 1); chk("ald_stall", a_stall, 0);
    chk("ald_maddr", m_addr, 32'h0010_0004); chk("ald_mrs", m_read_status, DM_WORD);
    chk("ald_msgn", m_load_signed, 1);
    tick();
    idle(); m_rdata = 32'hDEAD_BEEF; #1;
    chk("ald_arv", a_rvalid, 1); chk("ald_ard", a_rdata, 32'hDEAD_BEEF);
    chk("ald_brv", b_rvalid, 0); chk("ald_brd", b_rdata, 0);
    tick();
    #1; chk("ald_arv_once", a_rvalid, 0); chk("ald_ard0", a_rdata, 0);

    // B-only word store.
    b_req = 1; b_addr = 32'h0010_0010; b_wdata = 32'h0000_1234; b_write_status = DM_WORD;
    #1;
    chk("bst_gnt", b_grant, 1); chk("bst_mws", m_write_status, DM_WORD);
    chk("bst_mwd", m_wdata, 32'h1234); chk("bst_maddr", m_addr, 32'h0010_0010);
    chk("bst_mrs", m_read_status, DM_NONE); chk("bst_msgn", m_load_signed, 0);
    tick();
    idle(); m_rdata = 32'h5555_5555; #1;
    chk("bst_arv", a_rvalid, 0); chk("bst_brv", b_rvalid, 0);
    tick();

    // A read then B read back to back.
    a_req = 1; a_addr = 32'h40; a_read_status = DM_WORD;
    tick();
    idle(); b_req = 1; b_addr = 32'h80; b_read_status = DM_BYTE; m_rdata = 32'h1111_1111;
    #1;
    chk("b2b_bgnt", b_grant, 1); chk("b2b_arv", a_rvalid, 1);
    chk("b2b_ard", a_rdata, 32'h1111_1111); chk("b2b_brv1", b_rvalid, 0);
    tick();
    idle(); m_rdata = 32'h2222_2222; #1;
    chk("b2b_brv", b_rvalid, 1); chk("b2b_brd", b_rdata, 32'h2222_2222);
    chk("b2b_arv2", a_rvalid, 0); chk("b2b_ard2", a_rdata, 0);
    tick();

    // Continuous contention: A,A,A,A,B,A,A,A,A,B (no-op accesses still rotate).
    idle(); #1;
    both_rot("rot", 10, 16'b10_0001_0000);
    // Starve count clears when b_req drops: A,A, A alone, then A x4 and B.
    both_rot("pre", 2, 16'b0);
    idle(); a_req = 1; #1;
    chk("drop_agnt", a_grant, 1);
    tick();
    both_rot("clr", 5, 16'b1_0000);

    // Mid-operation reset drops the pending read response.
    idle(); a_req = 1; a_addr = 32'h44; a_read_status = DM_WORD;
    tick();
    rst_n = 0; b_req = 1; b_read_status = DM_WORD; m_rdata = 32'h3333_3333;
    #1;
    chk("mrst_arv", a_rvalid, 0); chk("mrst_ard", a_rdata, 0);
    chk_quiet("mrst");
    tick();
    rst_n = 1; a_read_status = DM_NONE; b_read_status = DM_NONE;
    #1;
    chk("rel_arv", a_rvalid, 0); chk("rel_brv", b_rvalid, 0);
    both_rot("rel", 5, 16'b1_0000);

    idle(); #1;
    chk_quiet("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive contended cycles port B may lose before it is forced a grant (legal range 1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge clk
- rst_n  in  1  synchronous active-low reset
- a_req  in  1  pipeline MEM-stage access request
- a_addr  in  32  pipeline byte address (execute result)
- a_wdata  in  32  pipeline store data
- a_read_status  in  2  pipeline load size, `DM_* encoding
- a_write_status  in  2  pipeline store size, `DM_* encoding
- a_load_signed  in  1  pipeline load sign-extend
- a_grant  out  1  pipeline access issued this cycle
- a_stall  out  1  freeze pipeline (a_req & ~a_grant)
- a_rvalid  out  1  pipeline load data valid
- a_rdata  out  32  pipeline load data
- b_req, b_addr[31:0], b_wdata[31:0], b_read_status[1:0], b_write_status[1:0]  in  loader/debug port, same meaning as port A; B loads always unsigned
- b_grant  out  1  loader access issued this cycle
- b_rvalid  out  1  loader load data valid
- b_rdata  out  32  loader load data
- m_addr  out  32  to daligner alu_result
- m_wdata  out  32  to daligner input_data
- m_read_status  out  2  to daligner read_status
- m_write_status  out  2  to daligner write_status
- m_load_signed  out  1  to daligner load_signed
- m_rdata  in  32  daligner read_output, valid one cycle after issue

Function
REQ-003 SHALL issue at most one access per cycle; grant is combinational from current requests and registered state.
REQ-004 SHALL, with only a_req high, grant A; with only b_req high, grant B; with neither, grant none.
REQ-005 SHALL, with both requests high, grant A unless starve_cnt == STARVE_LIMIT, in which case grant B.
REQ-006 SHALL keep 4-bit starve_cnt: increment when both request and A is granted; clear when B is granted or b_req low; saturates at STARVE_LIMIT.
REQ-007 SHALL drive m_* from the granted port's fields in the same cycle; with no grant, m_read_status and m_write_status SHALL be `DM_NONE and m_addr/m_wdata SHALL be 0.
REQ-008 SHALL force m_load_signed = a_load_signed when A granted, else 0.
REQ-009 SHALL register a 2-bit response owner {owner_a, owner_b} each cycle, set only when the granted access has read_status != `DM_NONE.
REQ-010 SHALL assert a_rvalid (b_rvalid) in the cycle after a granted A (B) read, for exactly one cycle, with a_rdata (b_rdata) = m_rdata; rdata SHALL be 0 when rvalid low.
REQ-011 SHALL complete stores in the grant cycle with no rvalid response.
REQ-012 SHALL sustain back-to-back grants: a read granted in cycle N and another in N+1 returns data in N+1 and N+2 respectively.
REQ-013 SHALL assert a_stall = a_req & ~a_grant combinationally; a stalled A request SHALL be re-presented unchanged by the pipeline and is not latched by this block.
REQ-014 SHALL treat a request with both statuses `DM_NONE as a legal no-op access that still consumes the grant.

Reset
REQ-015 SHALL, when rst_n low at posedge clk, clear starve_cnt, owner flags, a_rvalid, b_rvalid, a_rdata, b_rdata to 0.
REQ-016 SHALL, while rst_n low, drive a_grant=0, b_grant=0, a_stall=0, m_read_status=m_write_status=`DM_NONE regardless of requests.
REQ-017 SHALL drop any read response pending when reset asserts mid-operation; no rvalid in the cycle after reset releases.

Verification
REQ-018 A-only load addr 0x0010_0004 word, m_rdata=0xDEADBEEF -> a_grant same cycle, a_rvalid next cycle, a_rdata=0xDEADBEEF, b_rvalid=0.
REQ-019 Both request continuously, STARVE_LIMIT=4 -> grants A,A,A,A,B,A,A,A,A,B...; a_stall high only in B cycles.
REQ-020 B-only word store 0x0000_1234 at 0x0010_0010 -> m_write_status=word, m_wdata=0x1234 same cycle, no rvalid.
REQ-021 A read cycle N, B read cycle N+1 -> a_rvalid in N+1, b_rvalid in N+2, each with its own m_rdata.
REQ-022 A read granted, rst_n low next cycle -> no a_rvalid, all outputs zero/`DM_NONE; starve_cnt restarts at 0 after release.
REQ-023 Idle (no requests) -> m_read_status=m_write_status=`DM_NONE, no grants, no stall.
